turn_controller: RTL and testbench

TURN_CONTROLLER -- requirements
Module: turn_controller

---
 rtl/turn_controller_pkg.sv | 34 +++
 rtl/turn_controller_reveal_timer.sv | 31 +++
 rtl/turn_controller.sv | 155 +++++++++++++++
 tb/tb_turn_controller.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_controller_pkg.sv
// Shared definitions for the memory-game turn controller.
// State encoding, sizing constants and the player-advance rule.
package turn_controller_pkg;

    localparam int MAX_PLAYERS       = 4;
    localparam int NUM_CARDS         = 16;
    localparam int REVEAL_CYCLES_DEF = 50_000_000;
    localparam int PW                = $clog2(MAX_PLAYERS);
    localparam int CW                = $clog2(NUM_CARDS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SEL,
        REQ,
        CHECK,
        SHOW,
        NEXT,
        OVER
    } state_t;

    // N=0 still means two players; an out-of-range player wraps to 0.
    function automatic logic [PW-1:0] next_player(
        input logic [PW-1:0] cur,
        input logic [1:0]    n
    );
        logic [1:0] w_last;
        w_last = (n == 2'd0) ? 2'd1 : n;
        if (cur >= w_last) begin
            return '0;
        end
        return cur + PW'(1);
    endfunction

endpackage

// File: rtl/turn_controller_reveal_timer.sv
// Down-counter timing how long a flipped card stays on display.
// Load with the period minus one; done pulses on the last enabled cycle.
module reveal_timer #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = i_en && (r_cnt == '0);

endmodule

// File: rtl/turn_controller.sv
// Turn sequencing for a multi-player memory card game.
// Drives check requests, reveal timing, player rotation and win latch.
module turn_controller
    import turn_controller_pkg::*;
#(
    parameter int REVEAL_CYCLES = REVEAL_CYCLES_DEF,
    parameter int CNT_W         = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 new_game,
    input  logic [1:0]           N,
    input  logic                 sel_valid,
    input  logic [CW-1:0]        card_sel,
    input  logic                 go,
    input  logic                 W,
    output logic                 A,
    output logic [CW-1:0]        position_data,
    output logic                 statecombo_next_turn,
    output logic [PW-1:0]        cur_player,
    output logic                 reveal,
    output logic [NUM_CARDS-1:0] face_up,
    output logic                 flip_err,
    output logic                 game_over,
    output logic [PW-1:0]        winner
);

    state_t                r_state;
    logic                  r_a;
    logic [CW-1:0]         r_pos;
    logic                  r_next_turn;
    logic [PW-1:0]         r_cur;
    logic                  r_reveal;
    logic [NUM_CARDS-1:0]  r_face;
    logic                  r_flip_err;
    logic                  r_over;
    logic [PW-1:0]         r_winner;
    logic                  r_hit;
    logic                  r_win;

    logic                  w_load;
    logic                  w_en;
    logic                  w_done;

    assign w_load = (r_state == CHECK) && !new_game;
    assign w_en   = (r_state == SHOW) && !new_game;

    reveal_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst),
        .i_clr     (new_game),
        .i_load    (w_load),
        .i_load_val(CNT_W'(REVEAL_CYCLES - 1)),
        .i_en      (w_en),
        .o_done    (w_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_a         <= 1'b0;
            r_pos       <= '0;
            r_next_turn <= 1'b0;
            r_cur       <= '0;
            r_reveal    <= 1'b0;
            r_face      <= '0;
            r_flip_err  <= 1'b0;
            r_over      <= 1'b0;
            r_winner    <= '0;
            r_hit       <= 1'b0;
            r_win       <= 1'b0;
        end else begin
            r_a         <= 1'b0;
            r_next_turn <= 1'b0;
            r_flip_err  <= 1'b0;
            if (new_game) begin
                r_state  <= WAIT_SEL;
                r_pos    <= '0;
                r_cur    <= '0;
                r_reveal <= 1'b0;
                r_face   <= '0;
                r_over   <= 1'b0;
                r_winner <= '0;
                r_hit    <= 1'b0;
                r_win    <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_state <= WAIT_SEL;
                    end
                    WAIT_SEL: begin
                        if (sel_valid) begin
                            if (r_face[card_sel]) begin
                                r_flip_err <= 1'b1;
                            end else begin
                                r_pos            <= card_sel;
                                r_face[card_sel] <= 1'b1;
                                r_a              <= 1'b1;
                                r_state          <= REQ;
                            end
                        end
                    end
                    REQ: begin
                        r_state <= CHECK;
                    end
                    CHECK: begin
                        r_hit    <= go;
                        r_win    <= W;
                        r_reveal <= 1'b1;
                        r_state  <= SHOW;
                    end
                    SHOW: begin
                        if (w_done) begin
                            r_reveal <= 1'b0;
                            if (r_win) begin
                                r_over   <= 1'b1;
                                r_winner <= r_cur;
                                r_state  <= OVER;
                            end else if (r_hit) begin
                                r_state <= WAIT_SEL;
                            end else begin
                                r_next_turn <= 1'b1;
                                r_state     <= NEXT;
                            end
                        end
                    end
                    NEXT: begin
                        r_cur   <= next_player(r_cur, N);
                        r_face  <= '0;
                        r_state <= WAIT_SEL;
                    end
                    OVER: begin
                        r_state <= OVER;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign A                    = r_a;
    assign position_data        = r_pos;
    assign statecombo_next_turn = r_next_turn;
    assign cur_player           = r_cur;
    assign reveal               = r_reveal;
    assign face_up              = r_face;
    assign flip_err             = r_flip_err;
    assign game_over            = r_over;
    assign winner               = r_winner;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: timestamp-based reference model,
// directed scenarios with literal expectations, then random play.
module tb_turn_controller;

    localparam int R     = 4;
    localparam int NEVER = 1 << 30;

    logic        clk;
    logic        rst;
    logic        new_game;
    logic [1:0]  N;
    logic        sel_valid;
    logic [3:0]  card_sel;
    logic        go;
    logic        W;
    logic        A;
    logic [3:0]  position_data;
    logic        statecombo_next_turn;
    logic [1:0]  cur_player;
    logic        reveal;
    logic [15:0] face_up;
    logic        flip_err;
    logic        game_over;
    logic [1:0]  winner;

    int n_pass;
    int n_total;
    bit chk_en;

    turn_controller #(
        .REVEAL_CYCLES(R),
        .CNT_W        (3)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .new_game            (new_game),
        .N                   (N),
        .sel_valid           (sel_valid),
        .card_sel            (card_sel),
        .go                  (go),
        .W                   (W),
        .A                   (A),
        .position_data       (position_data),
        .statecombo_next_turn(statecombo_next_turn),
        .cur_player          (cur_player),
        .reveal              (reveal),
        .face_up             (face_up),
        .flip_err            (flip_err),
        .game_over           (game_over),
        .winner              (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: pc counts rising edges since reset; sel_p is the edge at
    // which the current card was accepted and every later event of that
    // flip is a fixed offset from it.
    int          pc;
    int          acc_from;
    int          sel_p;
    logic        m_hit;
    logic        m_win;
    logic [3:0]  m_pos;
    logic [15:0] m_face;
    logic [1:0]  m_cur;
    logic [1:0]  m_winner;
    logic        m_ferr;
    logic        m_over;

    function automatic void m_reset();
        pc       = 0;
        acc_from = 2;
        sel_p    = -1;
        m_hit    = 1'b0;
        m_win    = 1'b0;
        m_pos    = '0;
        m_face   = '0;
        m_cur    = '0;
        m_winner = '0;
        m_ferr   = 1'b0;
        m_over   = 1'b0;
    endfunction

    function automatic void m_step();
        int players;
        int c;
        pc++;
        m_ferr = 1'b0;
        if (new_game) begin
            acc_from = pc + 1;
            sel_p    = -1;
            m_hit    = 1'b0;
            m_win    = 1'b0;
            m_pos    = '0;
            m_face   = '0;
            m_cur    = '0;
            m_winner = '0;
            m_over   = 1'b0;
            return;
        end
        if (sel_p >= 0 && pc == sel_p + 2) begin
            m_hit = go;
            m_win = W;
        end
        if (sel_p >= 0 && pc == sel_p + 2 + R) begin
            if (m_win) begin
                m_over   = 1'b1;
                m_winner = m_cur;
            end else if (m_hit) begin
                acc_from = pc + 1;
            end else begin
                acc_from = pc + 2;
            end
        end
        if (sel_p >= 0 && pc == sel_p + 3 + R && !m_win && !m_hit) begin
            players = (N == 2'd0) ? 2 : int'(N) + 1;
            c = int'(m_cur) + 1;
            if (c >= players) c = 0;
            m_cur  = 2'(c);
            m_face = '0;
        end
        if (sel_valid && pc >= acc_from) begin
            if (m_face[card_sel]) begin
                m_ferr = 1'b1;
            end else begin
                sel_p            = pc;
                m_pos            = card_sel;
                m_face[card_sel] = 1'b1;
                acc_from         = NEVER;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (!rst) m_reset();
        else m_step();
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        logic        e_a;
        logic        e_rev;
        logic        e_nt;
        logic [28:0] act;
        logic [28:0] exp;
        if (chk_en) begin
            e_a   = (sel_p >= 0) && (pc == sel_p);
            e_rev = (sel_p >= 0) && (pc >= sel_p + 2) && (pc <= sel_p + 1 + R);
            e_nt  = (sel_p >= 0) && !m_hit && !m_win && (pc == sel_p + 2 + R);
            act = {A, position_data, statecombo_next_turn, cur_player, reveal,
                   face_up, flip_err, game_over, winner};
            exp = {e_a, m_pos, e_nt, m_cur, e_rev,
                   m_face, m_ferr, m_over, m_winner};
            check("cycle", 32'(act), 32'(exp));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the edge where the reveal period has just ended.
    task automatic flip(input logic [3:0] card, input logic g, input logic w);
        sel_valid = 1'b1;
        card_sel  = card;
        go        = g;
        W         = w;
        step();
        sel_valid = 1'b0;
        for (int i = 0; i < R + 2; i++) step();
    endtask

    initial begin
        int          cnt;
        logic [1:0]  seq [4];
        n_pass    = 0;
        n_total   = 0;
        chk_en    = 1'b0;
        rst       = 1'b0;
        new_game  = 1'b0;
        N         = 2'd1;
        sel_valid = 1'b0;
        card_sel  = '0;
        go        = 1'b0;
        W         = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_face", 32'(face_up), 32'h0);
        check("rst_over", 32'(game_over), 32'h0);
        rst = 1'b1;
        step();
        step();

        // Miss with two players
        N         = 2'd1;
        go        = 1'b0;
        sel_valid = 1'b1;
        card_sel  = 4'd5;
        step();
        sel_valid = 1'b0;
        check("t1_A", 32'(A), 32'h1);
        check("t1_pos", 32'(position_data), 32'h5);
        cnt = 0;
        for (int i = 0; i < R + 2; i++) begin
            step();
            if (reveal) cnt++;
        end
        check("t1_reveal_len", 32'(cnt), 32'(R));
        check("t1_next_turn", 32'(statecombo_next_turn), 32'h1);
        step();
        check("t1_cur", 32'(cur_player), 32'h1);
        check("t1_face", 32'(face_up), 32'h0);

        // Hit, then reselect the same card
        flip(4'd3, 1'b1, 1'b0);
        sel_valid = 1'b1;
        card_sel  = 4'd3;
        step();
        sel_valid = 1'b0;
        check("t2_flip_err", 32'(flip_err), 32'h1);
        check("t2_no_A", 32'(A), 32'h0);
        step();
        check("t2_no_A2", 32'(A), 32'h0);
        check("t2_cur", 32'(cur_player), 32'h1);
        check("t2_face3", 32'(face_up[3]), 32'h1);

        // Four players, four misses
        new_game = 1'b1;
        N        = 2'd3;
        step();
        new_game = 1'b0;
        check("t3_cur0", 32'(cur_player), 32'h0);
        seq = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 4; k++) begin
            flip(4'(k + 8), 1'b0, 1'b0);
            step();
            check("t3_seq", 32'(cur_player), 32'(seq[k]));
        end

        // Player 2 wins
        flip(4'd7, 1'b0, 1'b0);
        step();
        flip(4'd8, 1'b0, 1'b0);
        step();
        check("t4_cur2", 32'(cur_player), 32'h2);
        flip(4'd9, 1'b1, 1'b1);
        go = 1'b0;
        W  = 1'b0;
        check("t4_over", 32'(game_over), 32'h1);
        check("t4_winner", 32'(winner), 32'h2);
        sel_valid = 1'b1;
        card_sel  = 4'd0;
        step();
        sel_valid = 1'b0;
        check("t4_no_A", 32'(A), 32'h0);
        step();
        check("t4_no_A2", 32'(A), 32'h0);

        // Restart and select together during OVER
        new_game  = 1'b1;
        sel_valid = 1'b1;
        card_sel  = 4'd4;
        step();
        new_game  = 1'b0;
        sel_valid = 1'b0;
        check("t6_over", 32'(game_over), 32'h0);
        check("t6_no_A", 32'(A), 32'h0);
        step();
        check("t6_no_A2", 32'(A), 32'h0);
        check("t6_winner", 32'(winner), 32'h0);

        // Reset pulse during SHOW
        sel_valid = 1'b1;
        card_sel  = 4'd2;
        go        = 1'b0;
        step();
        sel_valid = 1'b0;
        step();
        step();
        step();
        check("t5_in_show", 32'(reveal), 32'h1);
        rst = 1'b0;
        m_reset();
        #2;
        check("t5_rst_reveal", 32'(reveal), 32'h0);
        check("t5_rst_face", 32'(face_up), 32'h0);
        step();
        rst       = 1'b1;
        sel_valid = 1'b1;
        card_sel  = 4'd6;
        step();
        check("t5_idle_A", 32'(A), 32'h0);
        check("t5_idle_nt", 32'(statecombo_next_turn), 32'h0);
        step();
        sel_valid = 1'b0;
        check("t5_ws_A", 32'(A), 32'h1);
        for (int i = 0; i < R + 4; i++) step();

        // Random play
        for (int i = 0; i < 4000; i++) begin
            if (!rst) begin
                rst = 1'b1;
            end else if ($urandom_range(299) == 0) begin
                rst = 1'b0;
                m_reset();
            end
            new_game  = ($urandom_range(79) == 0);
            sel_valid = ($urandom_range(2) == 0);
            card_sel  = ($urandom_range(1) == 0) ? 4'($urandom_range(3))
                                                 : 4'($urandom_range(15));
            go        = 1'($urandom_range(1));
            W         = ($urandom_range(5) == 0);
            if ($urandom_range(199) == 0) N = 2'($urandom_range(3));
            step();
        end
        rst       = 1'b1;
        new_game  = 1'b0;
        sel_valid = 1'b0;
        step();
        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
